clock_set_ctrl: RTL and testbench

//   Controller for the BCD HH:MM time counter. Generates the minute-advance tick
//   in RUN mode. Runs a two-button edit FSM (mode/inc) that captures the current

---
 rtl/clock_set_ctrl.sv | 128 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: minute tick prescaler and two-button HH:MM edit FSM for the BCD time counter.
// Define AUTO_REPEAT_EN to auto-repeat increments while btn_inc is held in an edit state.
module clock_set_ctrl #(
  parameter int TICKS_PER_MIN = 60,
  parameter int EDIT_TIMEOUT  = 600,
  parameter int BLINK_DIV     = 8,
  parameter int REPEAT_DLY    = 16,
  parameter int REPEAT_RATE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hourst,
  input  logic [3:0] cur_hoursu,
  input  logic [3:0] cur_mint,
  input  logic [3:0] cur_minu,
  output logic       tick,
  output logic       load,
  output logic [3:0] set_hourst,
  output logic [3:0] set_hoursu,
  output logic [3:0] set_mint,
  output logic [3:0] set_minu,
  output logic [1:0] edit_field,
  output logic       blink
);
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam int PW = $clog2(TICKS_PER_MIN);
  localparam int IW = $clog2(EDIT_TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int RW = $clog2(REPEAT_DLY + 1);
  // Encoding makes edit_field equal the state outside COMMIT and lets mode advance by +1.
  typedef enum logic [1:0] {RUN = 2'b00, EDIT_HR = 2'b01, EDIT_MIN = 2'b10, COMMIT = 2'b11} state_t;
  state_t state_q, state_d;
  logic mode_q, inc_q;
  logic [15:0] sh_q, sh_d, set_q, set_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic tick_q, tick_d, load_q, load_d, blink_q, blink_d;
  logic [1:0] ef_q, ef_d;
  logic press_mode, press_inc, rep, bump, any_press, edit, edit_d, stay, wrap, bwrap, timeout;

  function automatic logic [7:0] inc_hr(input logic [7:0] h);
    return (h[7:4] > 4'd2 || (h[7:4] == 4'd2 && h[3:0] >= 4'd3)) ? 8'h00 :
           (h[3:0] >= 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    return (m[7:4] > 4'd5 || (m[7:4] == 4'd5 && m[3:0] >= 4'd9)) ? 8'h00 :
           (m[3:0] >= 4'd9) ? {m[7:4] + 4'd1, 4'd0} : {m[7:4], m[3:0] + 4'd1};
  endfunction

  always_comb begin
    press_mode = btn_mode & ~mode_q;
    press_inc  = btn_inc & ~inc_q;
    edit       = state_q == EDIT_HR || state_q == EDIT_MIN;
    rep        = REP_EN && edit && btn_inc && !press_inc && rcnt_q == RW'(REPEAT_DLY);
    bump       = (press_inc | rep) & ~press_mode;
    any_press  = press_mode | press_inc | rep;
    timeout    = edit && !any_press && idle_q == IW'(EDIT_TIMEOUT - 1);
    state_d    = (state_q == COMMIT || timeout) ? RUN :
                 press_mode ? state_t'(state_q + 2'd1) : state_q;
    stay       = state_d == state_q;
    edit_d     = state_d == EDIT_HR || state_d == EDIT_MIN;
    wrap       = cnt_q == PW'(TICKS_PER_MIN - 1);
    bwrap      = bcnt_q == BW'(BLINK_DIV - 1);
    sh_d       = (state_q == RUN && press_mode) ? {cur_hourst, cur_hoursu, cur_mint, cur_minu} :
                 (bump && state_q == EDIT_HR) ? {inc_hr(sh_q[15:8]), sh_q[7:0]} :
                 (bump && state_q == EDIT_MIN) ? {sh_q[15:8], inc_min(sh_q[7:0])} : sh_q;
    cnt_d      = (state_q == RUN && stay) ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    tick_d     = state_q == RUN && stay && wrap;
    idle_d     = (edit && stay && !any_press) ? idle_q + 1'b1 : '0;
    bcnt_d     = (edit_d && stay && !bwrap) ? bcnt_q + 1'b1 : '0;
    blink_d    = !edit_d ? 1'b0 : !stay ? 1'b1 : bwrap ? ~blink_q : blink_q;
    // A repeat reloads the counter so the next one lands REPEAT_RATE cycles later.
    rcnt_d     = !(REP_EN && edit && stay && btn_inc) ? '0 :
                 press_inc ? RW'(1) :
                 rep ? RW'(REPEAT_DLY - REPEAT_RATE + 1) :
                 (rcnt_q != '0) ? rcnt_q + 1'b1 : '0;
    load_d     = state_d == COMMIT;
    set_d      = load_d ? sh_q : set_q;
    ef_d       = (state_d == COMMIT) ? 2'b00 : state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      mode_q  <= 1'b1;
      inc_q   <= 1'b1;
      sh_q    <= '0;
      set_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
      blink_q <= 1'b0;
      ef_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      sh_q    <= sh_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      blink_q <= blink_d;
      ef_q    <= ef_d;
    end
  end

  assign tick       = tick_q;
  assign load       = load_q;
  assign blink      = blink_q;
  assign edit_field = ef_q;
  assign {set_hourst, set_hoursu, set_mint, set_minu} = set_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench for clock_set_ctrl with a load scoreboard.
module tb_clock_set_ctrl;
`ifdef AUTO_REPEAT_EN
  localparam int HOLD = 28;
  localparam logic [7:0] T6_HR = 8'h14;
`else
  localparam int HOLD = 18;
  localparam logic [7:0] T6_HR = 8'h11;
`endif
  logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] cur_hourst = '0, cur_hoursu = '0, cur_mint = '0, cur_minu = '0;
  logic tick, load, blink;
  logic [3:0] set_hourst, set_hoursu, set_mint, set_minu;
  logic [1:0] edit_field;
  int checks = 0, errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  clock_set_ctrl #(.TICKS_PER_MIN(4), .EDIT_TIMEOUT(20), .BLINK_DIV(8), .REPEAT_DLY(16), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hourst(cur_hourst), .cur_hoursu(cur_hoursu), .cur_mint(cur_mint), .cur_minu(cur_minu),
    .tick(tick), .load(load), .set_hourst(set_hourst), .set_hoursu(set_hoursu),
    .set_mint(set_mint), .set_minu(set_minu), .edit_field(edit_field), .blink(blink)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(1);
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_hourst, cur_hoursu, cur_mint, cur_minu} = v;
  endtask

  function automatic logic [15:0] set_val();
    return {set_hourst, set_hoursu, set_mint, set_minu};
  endfunction

  always @(negedge clk) begin
    if (!rst && load) begin
      chk("load_queued", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) chk("load_value", set_val(), sb.pop_front());
    end
  end

  initial begin
    step(2);
    chk("rst_ctrl", {11'b0, tick, load, edit_field, blink}, 16'h0000);
    chk("rst_set", set_val(), 16'h0000);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step(1);
      chk($sformatf("t1_tick%0d", k), 16'(tick), 16'((k % 4) == 0));
    end
    chk("t1_run_idle", {13'b0, edit_field, blink}, 16'h0000);
    // T2: 23:59 -> hours wrap to 00, minutes untouched
    set_cur(16'h2359);
    press(1'b1, 1'b0);
    chk("t2_ef_hr", 16'(edit_field), 16'd1);
    chk("t2_blink_on", 16'(blink), 16'd1);
    chk("t2_no_tick", 16'(tick), 16'd0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("t2_ef_min", 16'(edit_field), 16'd2);
    sb.push_back(16'h0059);
    press(1'b1, 1'b0);
    chk("t2_ef_run", 16'(edit_field), 16'd0);
    chk("t2_load_off", 16'(load), 16'd0);
    chk("t2_set_hold", set_val(), 16'h0059);
    // T3: 12:59 -> minutes wrap without hours carry
    set_cur(16'h1259);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    sb.push_back(16'h1200);
    press(1'b1, 1'b0);
    chk("t3_set", set_val(), 16'h1200);
    // out-of-range capture normalises on first inc
    set_cur(16'h2773);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    sb.push_back(16'h0000);
    press(1'b1, 1'b0);
    chk("norm_set", set_val(), 16'h0000);
    // units carry into tens for both fields
    set_cur(16'h0909);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    sb.push_back(16'h1010);
    press(1'b1, 1'b0);
    chk("carry_set", set_val(), 16'h1010);
    // T4: idle timeout after 20 cycles in EDIT_HR, no load, tick resumes
    press(1'b1, 1'b0);
    chk("t4_blink_a1", 16'(blink), 16'd1);
    step(6);
    chk("t4_blink_a7", 16'(blink), 16'd1);
    step(1);
    chk("t4_blink_a8", 16'(blink), 16'd0);
    step(11);
    chk("t4_ef_before", 16'(edit_field), 16'd1);
    step(1);
    chk("t4_ef_timeout", 16'(edit_field), 16'd0);
    chk("t4_blink_run", 16'(blink), 16'd0);
    step(3);
    chk("t4_tick_early", 16'(tick), 16'd0);
    step(1);
    chk("t4_tick_resume", 16'(tick), 16'd1);
    chk("t4_set_kept", set_val(), 16'h1010);
    // T5: simultaneous mode+inc, then async reset in EDIT_MIN
    set_cur(16'h0730);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("t5_ef_min", 16'(edit_field), 16'd2);
    sb.push_back(16'h0730);
    press(1'b1, 1'b0);
    chk("t5_set", set_val(), 16'h0730);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t5_ef_min2", 16'(edit_field), 16'd2);
    rst = 1'b1;
    #1;
    chk("t5_async_ef", 16'(edit_field), 16'd0);
    chk("t5_async_set", set_val(), 16'h0000);
    #2;
    rst = 1'b0;
    step(5);
    chk("t5_after_rst", {11'b0, load, 1'b0, edit_field, blink}, 16'h0000);
    // T6: hold inc; auto-repeat only with the macro
    set_cur(16'h1000);
    press(1'b1, 1'b0);
    btn_inc = 1'b1;
    step(HOLD);
    btn_inc = 1'b0;
    press(1'b1, 1'b0);
    chk("t6_ef_min", 16'(edit_field), 16'd2);
    sb.push_back({T6_HR, 8'h00});
    press(1'b1, 1'b0);
    chk("t6_set", set_val(), {T6_HR, 8'h00});
    step(2);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
